// File: rtl/alluvial_seq_pkg.sv
// Shared types for the byte-serial ADD/SUB sequencer.
// Op codes are 32-bit encoded to match the request channel width.
package alluvial_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [31:0] {
        ADD = 32'd0,
        SUB = 32'd1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alluvial_seq_byte_adder.sv
// Single 8-bit adder slice with carry-in, shared across all bytes.
module alluvial_byte_adder
    import alluvial_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/alluvial_seq.sv
// Byte-serial wide ADD/SUB controller around one 8-bit adder slice.
// Define ALLUVIAL_SEQ_PERF_EN to add the perf_ops handshake counter.
module alluvial_seq
    import alluvial_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_op,
    input  logic [8*BYTES-1:0]   req_a,
    input  logic [8*BYTES-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8*BYTES-1:0]   rsp_result,
    output logic                 rsp_error
`ifdef ALLUVIAL_SEQ_PERF_EN
    ,
    output logic [15:0]          perf_ops
`endif
);

    localparam int W    = 8 * BYTES;
    localparam int IDXW = $clog2(BYTES);
    localparam logic [IDXW-1:0] LAST = IDXW'(BYTES - 1);

    seq_state_e      state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            err_q, err_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;

    logic [7:0]      slice_sum;
    logic            slice_cout;

    // Operands shift right each step, so the slice always sees byte 0.
    alluvial_byte_adder u_slice (
        .a    (a_q[7:0]),
        .b    (b_q[7:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_op == 32'(ADD)) begin
                        a_d     = req_a;
                        b_d     = req_b;
                        carry_d = 1'b0;
                        sub_d   = 1'b0;
                        idx_d   = '0;
                        state_d = RUN;
                    end else if (req_op == 32'(SUB)) begin
                        a_d     = req_a;
                        b_d     = ~req_b;
                        carry_d = 1'b1;
                        sub_d   = 1'b1;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // Result fills from the top; after BYTES steps byte 0 sits at the bottom.
                a_d     = a_q >> 8;
                b_d     = b_q >> 8;
                res_d   = {slice_sum, res_q[W-1:8]};
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    err_d   = sub_q ? ~slice_cout : slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign rsp_result = res_q;
    assign rsp_error  = err_q;

`ifdef ALLUVIAL_SEQ_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (rsp_valid && rsp_ready && perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_ops = perf_q;
`endif

endmodule

// File: doc/alluvial_seq.md
Name: alluvial_seq

Overview:
- Multi-cycle controller that runs wide ADD/SUB operations byte-serially through a single 8-bit adder slice, propagating carry between bytes.
- Sits between a requester (valid/ready request channel) and a consumer (valid/ready response channel).
- Lets the 8-bit alluvial arithmetic datapath serve operands of BYTES*8 bits.

Parameters:
- BYTES, 4: operand width in bytes (legal range 2..16); internal data width W = 8*BYTES.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  32  operation code, Op encoding.
- req_a  input  W  operand A.
- req_b  input  W  operand B.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  W  result.
- rsp_error  output  1  ADD: unsigned overflow (final carry=1); SUB: borrow (final carry=0); unknown op: 1.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_error=0; byte index=0; carry=0.
  - Reset overrides everything, including mid-RUN and mid-DONE; any in-flight operation is discarded without a response.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1. Accept when req_valid=1 at an edge.
  - Op ADD: latch a, b; carry=0; idx=0; go to RUN.
  - Op SUB: latch a and ~b; carry=1; idx=0; go to RUN.
  - Any other op: rsp_result=0, rsp_error=1, go to DONE (response latency 1 edge).
- RUN:
  - req_ready=0. Each edge computes {c, s} = a_byte[idx] + b_byte[idx] + carry.
  - Writes s into result byte idx, carry=c, idx=idx+1.
  - On the edge processing idx=BYTES-1: rsp_error = (op==ADD) ? c : ~c; go to DONE.
  - Latency: rsp_valid first high after exactly BYTES edges following the accepting edge.
- DONE:
  - rsp_valid=1; rsp_result and rsp_error held stable while rsp_ready=0 (no glitch, no change).
  - On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
  - A new request is never accepted in the same edge as the response handshake; minimum request-to-request spacing is BYTES+2 edges.
- req_valid while req_ready=0: ignored, no state change.
- Carry chain is strictly LSB-first; idx never exceeds BYTES-1.
- All arithmetic is modulo 2^W.
- req_* inputs are sampled only at the accepting edge; later changes have no effect.

Optional Feature:
- Macro: ALLUVIAL_SEQ_PERF_EN.
- Defined:
  - Adds output port perf_ops (16 bits).
  - Counts completed response handshakes (rsp_valid & rsp_ready); saturates at 0xFFFF.
  - Reset to 0 by rst_n.
- Undefined:
  - Port and counter absent.
  - All other behaviour identical.

Decomposition:
- Package alluvial_pkg:
  - Op enum (ADD=0, SUB=1), 32-bit encoded, verilator public.
  - SeqState enum (IDLE, RUN, DONE).
- Sub-module alluvial_byte_adder:
  - Combinational 8-bit adder with carry-in.
  - Ports: a[7:0], b[7:0], cin, sum[7:0], cout.
  - Instantiated once in alluvial_seq.

Test Plan (BYTES=4):
- ADD 0x000000FF + 0x00000001 -> rsp_result=0x00000100, rsp_error=0; rsp_valid high exactly 4 edges after accept; req_ready=0 during RUN.
- ADD 0xFFFFFFFF + 0x00000001 -> rsp_result=0x00000000, rsp_error=1. SUB 7-5 -> 0x00000002, rsp_error=0. SUB 5-7 -> 0xFFFFFFFE, rsp_error=1.
- req_op=7, a=0x12345678 -> rsp_result=0, rsp_error=1, rsp_valid 1 edge after accept.
- ADD 0x01020304+0x10203040, rsp_ready held 0 for 3 cycles -> rsp_result=0x11223344 stable throughout; req_valid pulses ignored; rsp_valid drops 1 edge after rsp_ready=1; req_ready=1 next cycle.
- rst_n=0 for one edge while in RUN at idx=2 -> next cycle state IDLE, rsp_valid=0, rsp_result=0, req_ready=1; next ADD 3+4 -> 0x00000007, rsp_error=0.
- ALLUVIAL_SEQ_PERF_EN: 3 completed ops -> perf_ops=3; an op aborted by reset is not counted.
